// File: rtl/bitstream_pkg.sv
// bitstream_pkg
// Shared constants for the bitstream window slice (bitstream_window and
// bitstream_shift_merge).
//   WORD_WIDTH    : width of the upstream FIFO data word
//   WINDOW_WIDTH  : width of the peek window handed to the decoder
//   ADV_WIDTH     : width of the decoder's advance request
//   BUF_WIDTH     : staging buffer width, two FIFO words
//   FILL_WIDTH    : width of the buffer occupancy count (0..BUF_WIDTH)
//   BYTE_WIDTH    : byte size used for byte-alignment
//   BIT_POS_WIDTH : width of the bit-in-byte position counter
package bitstream_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int WINDOW_WIDTH  = 24;
  localparam int ADV_WIDTH     = 5;
  localparam int BUF_WIDTH     = 2 * WORD_WIDTH;
  localparam int FILL_WIDTH    = $clog2(BUF_WIDTH) + 1;
  localparam int BYTE_WIDTH    = 8;
  localparam int BIT_POS_WIDTH = $clog2(BYTE_WIDTH);

  // Bits to drop to reach the next byte boundary from bit position pos.
  // In modulo-8 arithmetic (8 - pos) mod 8 is simply the negation of pos.
  function automatic logic [BIT_POS_WIDTH-1:0] align_drop(
    input logic [BIT_POS_WIDTH-1:0] pos
  );
    return BIT_POS_WIDTH'(~pos + 1'b1);
  endfunction

endpackage

// File: rtl/bitstream_shift_merge.sv
// bitstream_shift_merge
// Combinational barrel-shift and merge for the bitstream staging buffer.
// Consumed bits are shifted out at the MSB end, and an arriving FIFO word is
// placed directly behind the remaining valid bits.
//   buf_cur  : current buffer, valid bits left-aligned at the MSB
//   cons     : bits consumed this cycle
//   word     : arriving FIFO word, MSB is earliest stream bit
//   fill_a   : valid bits left after consumption (at most WORD_WIDTH when
//              word_en is set)
//   word_en  : merge word into the buffer
//   buf_next : resulting buffer contents
module bitstream_shift_merge
  import bitstream_pkg::*;
(
  input  logic [BUF_WIDTH-1:0]  buf_cur,
  input  logic [FILL_WIDTH-1:0] cons,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic [FILL_WIDTH-1:0] fill_a,
  input  logic                  word_en,
  output logic [BUF_WIDTH-1:0]  buf_next
);

  logic [FILL_WIDTH-1:0] ins_shift;
  logic [BUF_WIDTH-1:0]  word_ext;
  logic [BUF_WIDTH-1:0]  shifted;

  // Left shift by cons drops consumed bits and fills with zeros, so every
  // bit below the valid region stays zero and an OR is enough to merge.
  always_comb begin
    ins_shift = FILL_WIDTH'(WORD_WIDTH) - fill_a;
    word_ext  = {{(BUF_WIDTH-WORD_WIDTH){1'b0}}, word} << ins_shift;
    shifted   = buf_cur << cons;
    buf_next  = word_en ? (shifted | word_ext) : shifted;
  end

endmodule

// File: rtl/bitstream_window.sv
// bitstream_window
// Turns a stream of FIFO words into a left-aligned peek window for a
// variable-length decoder, with per-cycle advance, byte alignment and flush.
//   clk, rst      : clock, synchronous active-low reset
//   fifo_dout     : FIFO read data, MSB is the earliest stream bit
//   fifo_valid    : FIFO read acknowledge (one cycle after fifo_rd_en)
//   fifo_empty    : FIFO empty flag
//   fifo_rd_en    : FIFO read request (combinational)
//   advance       : bits consumed by the decoder this cycle
//   align         : also discard up to the next byte boundary
//   flush         : drop all buffered and in-flight data
//   window        : next WINDOW_WIDTH stream bits, MSB first
//   window_valid  : buffer holds at least WINDOW_WIDTH bits
//   byte_aligned  : window MSB sits on a byte boundary
//   fill          : number of valid buffered bits
//   error         : sticky protocol-violation flag
module bitstream_window
  import bitstream_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD_WIDTH-1:0]   fifo_dout,
  input  logic                    fifo_valid,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [ADV_WIDTH-1:0]    advance,
  input  logic                    align,
  input  logic                    flush,
  output logic [WINDOW_WIDTH-1:0] window,
  output logic                    window_valid,
  output logic                    byte_aligned,
  output logic [FILL_WIDTH-1:0]   fill,
  output logic                    error
);

  logic [BUF_WIDTH-1:0]     buf_q;
  logic [FILL_WIDTH-1:0]    fill_q;
  logic                     pending_q;
  logic                     discard_q;
  logic [BIT_POS_WIDTH-1:0] bit_pos_q;
  logic                     error_q;
  logic                     err_mask_q;
  logic                     window_valid_q;
  logic                     byte_aligned_q;

  logic [ADV_WIDTH-1:0]     adv_eff;
  logic                     adv_bad;
  logic [FILL_WIDTH-1:0]    fill_adv;
  logic [BIT_POS_WIDTH-1:0] pos_adv;
  logic [BIT_POS_WIDTH-1:0] drop;
  logic                     align_bad;
  logic [FILL_WIDTH-1:0]    cons;
  logic [FILL_WIDTH-1:0]    fill_a;
  logic                     word_en;
  logic [BUF_WIDTH-1:0]     merged;
  logic [BUF_WIDTH-1:0]     buf_next;
  logic [FILL_WIDTH-1:0]    fill_next;
  logic [BIT_POS_WIDTH-1:0] bit_pos_next;
  logic                     pending_next;
  logic                     discard_next;
  logic                     error_next;

  bitstream_shift_merge u_shift_merge (
    .buf_cur  (buf_q),
    .cons     (cons),
    .word     (fifo_dout),
    .fill_a   (fill_a),
    .word_en  (word_en),
    .buf_next (merged)
  );

  // Consumption: advance first, then the optional alignment drop. Flush
  // overrides both and suppresses their error checks.
  always_comb begin
    adv_eff   = '0;
    adv_bad   = 1'b0;
    drop      = '0;
    align_bad = 1'b0;
    if (!flush) begin
      if (advance > ADV_WIDTH'(WINDOW_WIDTH)) begin
        adv_bad = 1'b1;
      end else if (window_valid_q) begin
        adv_eff = advance;
      end else if (advance != '0) begin
        adv_bad = 1'b1;
      end
    end
    fill_adv = fill_q - FILL_WIDTH'(adv_eff);
    pos_adv  = bit_pos_q + BIT_POS_WIDTH'(adv_eff);
    if (align && !flush) begin
      if (fill_adv >= FILL_WIDTH'(align_drop(pos_adv))) begin
        drop = align_drop(pos_adv);
      end else begin
        align_bad = 1'b1;
      end
    end
    cons   = FILL_WIDTH'(adv_eff) + FILL_WIDTH'(drop);
    fill_a = fill_q - cons;
  end

  // Read control and next-state. Only one read is ever outstanding, and a
  // word is requested only when it is sure to fit behind fill_a.
  // A word arriving during flush is dropped on the spot; discard is only
  // needed when a read is still outstanding with nothing delivered yet.
  always_comb begin
    fifo_rd_en = rst & ~flush & ~fifo_empty & ~pending_q
               & (fill_a <= FILL_WIDTH'(WORD_WIDTH));
    word_en    = fifo_valid & pending_q & ~discard_q & ~flush;

    buf_next     = flush ? '0 : merged;
    fill_next    = flush ? '0 :
                   (word_en ? fill_a + FILL_WIDTH'(WORD_WIDTH) : fill_a);
    bit_pos_next = flush ? '0 : bit_pos_q + cons[BIT_POS_WIDTH-1:0];

    pending_next = pending_q;
    if (fifo_rd_en) begin
      pending_next = 1'b1;
    end else if (fifo_valid) begin
      pending_next = 1'b0;
    end

    discard_next = discard_q;
    if (fifo_valid && pending_q) begin
      discard_next = 1'b0;
    end
    if (flush && pending_q && !fifo_valid) begin
      discard_next = 1'b1;
    end

    error_next = error_q
               | (~err_mask_q & (adv_bad | align_bad | (fifo_valid & ~pending_q)));
  end

  // State registers. err_mask_q hides the first cycle after reset so a word
  // requested before reset and delivered afterwards is not flagged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q          <= '0;
      fill_q         <= '0;
      pending_q      <= 1'b0;
      discard_q      <= 1'b0;
      bit_pos_q      <= '0;
      error_q        <= 1'b0;
      err_mask_q     <= 1'b1;
      window_valid_q <= 1'b0;
      byte_aligned_q <= 1'b1;
    end else begin
      buf_q          <= buf_next;
      fill_q         <= fill_next;
      pending_q      <= pending_next;
      discard_q      <= discard_next;
      bit_pos_q      <= bit_pos_next;
      error_q        <= error_next;
      err_mask_q     <= 1'b0;
      window_valid_q <= (fill_next >= FILL_WIDTH'(WINDOW_WIDTH));
      byte_aligned_q <= (bit_pos_next == '0);
    end
  end

  assign window       = buf_q[BUF_WIDTH-1 -: WINDOW_WIDTH];
  assign window_valid = window_valid_q;
  assign byte_aligned = byte_aligned_q;
  assign fill         = fill_q;
  assign error        = error_q;

endmodule

// File: tb/tb_bitstream_window.sv
// tb_bitstream_window
// Scoreboard bench for bitstream_window. A FIFO model feeds words with
// one-cycle latency; a bit-queue reference model predicts the window state
// after every clock edge and a separate monitor compares it.
module tb_bitstream_window;
  import bitstream_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fifo_dout;
  logic        fifo_valid;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [4:0]  advance;
  logic        align;
  logic        flush;
  logic [23:0] window;
  logic        window_valid;
  logic        byte_aligned;
  logic [6:0]  fill;
  logic        error;

  always #5 clk = ~clk;

  bitstream_window dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_dout    (fifo_dout),
    .fifo_valid   (fifo_valid),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .advance      (advance),
    .align        (align),
    .flush        (flush),
    .window       (window),
    .window_valid (window_valid),
    .byte_aligned (byte_aligned),
    .fill         (fill),
    .error        (error)
  );

  typedef struct {
    logic [23:0] window;
    logic        window_valid;
    logic [6:0]  fill;
    logic        byte_aligned;
    logic        error;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fifo_q[$];
  int          num_checks = 0;
  int          num_fail   = 0;

  // reference model state
  bit          m_bits[$];
  bit          m_pending;
  bit          m_discard;
  bit          m_error;
  bit          m_mask;
  int          m_bitpos;

  bit          rd_prev = 1'b0;
  logic [31:0] rd_word = 32'h0;
  int          rd_count = 0;
  bit          rd_adjacent = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    e.window = '0;
    for (int i = 0; i < 24; i++) begin
      if (i < m_bits.size()) e.window[23-i] = m_bits[i];
    end
    e.fill         = 7'(m_bits.size());
    e.window_valid = (m_bits.size() >= 24);
    e.byte_aligned = (m_bitpos == 0);
    e.error        = m_error;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive inputs at the falling edge, sample rd_en, run
  // the FIFO and reference models, queue the state expected after the edge.
  task automatic applyStimulus(input bit rst_n, input int adv, input bit al,
                               input bit fl, input bit stray);
    bit          v;
    bit          rd;
    bit          exp_rd;
    bit          empty_now;
    logic [31:0] w;
    int          fill_now;
    int          eff;
    int          drop;
    int          cons;
    bit          wv;
    @(negedge clk);
    v         = rd_prev | stray;
    w         = rd_prev ? rd_word : 32'hBAD0BAD0;
    empty_now = (fifo_q.size() == 0);
    rst        = rst_n;
    advance    = 5'(adv);
    align      = al;
    flush      = fl;
    fifo_valid = v;
    fifo_dout  = w;
    fifo_empty = empty_now;
    #1;
    rd = fifo_rd_en;
    if (rd) begin
      rd_word = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'hDEADDEAD;
      if (rd_prev) rd_adjacent = 1'b1;
      rd_count++;
    end

    exp_rd = 1'b0;
    if (!rst_n) begin
      m_bits.delete();
      m_pending = 1'b0;
      m_discard = 1'b0;
      m_error   = 1'b0;
      m_mask    = 1'b1;
      m_bitpos  = 0;
    end else if (fl) begin
      if (v && !m_pending && !m_mask) m_error = 1'b1;
      if (m_pending && !v) m_discard = 1'b1;
      else if (m_pending && v) m_discard = 1'b0;
      m_bits.delete();
      m_bitpos  = 0;
      m_pending = rd ? 1'b1 : (v ? 1'b0 : m_pending);
      m_mask    = 1'b0;
    end else begin
      fill_now = m_bits.size();
      wv       = (fill_now >= 24);
      eff      = (wv && adv <= 24) ? adv : 0;
      if (!m_mask && (adv > 24 || (adv != 0 && !wv))) m_error = 1'b1;
      drop = al ? (8 - ((m_bitpos + eff) % 8)) % 8 : 0;
      if (al && (fill_now - eff) < drop) begin
        drop = 0;
        if (!m_mask) m_error = 1'b1;
      end
      cons = eff + drop;
      for (int i = 0; i < cons; i++) void'(m_bits.pop_front());
      m_bitpos = (m_bitpos + cons) % 8;
      exp_rd = !empty_now && !m_pending && ((fill_now - cons) <= 32);
      if (v) begin
        if (!m_pending) begin
          if (!m_mask) m_error = 1'b1;
        end else if (m_discard) begin
          m_discard = 1'b0;
        end else begin
          for (int i = 0; i < 32; i++) m_bits.push_back(w[31-i]);
        end
      end
      m_pending = rd ? 1'b1 : (v ? 1'b0 : m_pending);
      m_mask    = 1'b0;
    end
    checkOutput("rd_en", 32'(rd), 32'(exp_rd));
    rd_prev = rd;
    pushExpected();
  endtask

  // Monitor: after every rising edge, compare the DUT outputs with the
  // next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("window",       32'(window),       32'(e.window));
        checkOutput("window_valid", 32'(window_valid), 32'(e.window_valid));
        checkOutput("fill",         32'(fill),         32'(e.fill));
        checkOutput("byte_aligned", 32'(byte_aligned), 32'(e.byte_aligned));
        checkOutput("error",        32'(error),        32'(e.error));
      end
    end
  end

  task automatic afterEdge();
    @(posedge clk);
    #3;
  endtask

  initial begin
    int cycles;
    int adv;
    bit al;
    rst        = 1'b0;
    advance    = '0;
    align      = 1'b0;
    flush      = 1'b0;
    fifo_valid = 1'b0;
    fifo_dout  = '0;
    fifo_empty = 1'b1;

    // reset state
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    afterEdge();
    checkOutput("reset_window",       32'(window),       32'h0);
    checkOutput("reset_window_valid", 32'(window_valid), 32'h0);
    checkOutput("reset_byte_aligned", 32'(byte_aligned), 32'h1);
    checkOutput("reset_error",        32'(error),        32'h0);

    // two words, no consumption
    fifo_q.push_back(32'h12345678);
    fifo_q.push_back(32'h9ABCDEF0);
    rd_count    = 0;
    rd_adjacent = 1'b0;
    repeat (5) applyStimulus(1, 0, 0, 0, 0);
    afterEdge();
    checkOutput("fill_two_words", 32'(fill),        32'd64);
    checkOutput("window_first",   32'(window),      32'h123456);
    checkOutput("wv_two_words",   32'(window_valid), 32'h1);
    checkOutput("rd_pulses",      32'(rd_count),    32'd2);
    checkOutput("rd_adjacent",    32'(rd_adjacent), 32'h0);

    // advance 4 then 20
    applyStimulus(1, 4, 0, 0, 0);
    afterEdge();
    checkOutput("window_adv4", 32'(window),       32'h234567);
    checkOutput("fill_adv4",   32'(fill),         32'd60);
    checkOutput("ba_adv4",     32'(byte_aligned), 32'h0);
    applyStimulus(1, 20, 0, 0, 0);
    afterEdge();
    checkOutput("window_adv20", 32'(window),       32'h789ABC);
    checkOutput("fill_adv20",   32'(fill),         32'd40);
    checkOutput("ba_adv20",     32'(byte_aligned), 32'h1);

    // advance 3 with align: one byte consumed in total
    applyStimulus(1, 3, 1, 0, 0);
    afterEdge();
    checkOutput("window_align", 32'(window),       32'h9ABCDE);
    checkOutput("fill_align",   32'(fill),         32'd32);
    checkOutput("ba_align",     32'(byte_aligned), 32'h1);
    checkOutput("error_align",  32'(error),        32'h0);

    // drain below the window, then an illegal advance
    applyStimulus(1, 24, 0, 0, 0);
    afterEdge();
    checkOutput("fill_drain",   32'(fill),         32'd8);
    checkOutput("wv_drain",     32'(window_valid), 32'h0);
    checkOutput("window_drain", 32'(window),       32'hF00000);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    afterEdge();
    checkOutput("error_sticky", 32'(error), 32'h1);
    checkOutput("fill_ignored", 32'(fill),  32'd8);

    // flush with a word in flight
    fifo_q.push_back(32'hDEADBEEF);
    fifo_q.push_back(32'hCAFEF00D);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    afterEdge();
    checkOutput("fill_flush",   32'(fill),         32'd0);
    checkOutput("wv_flush",     32'(window_valid), 32'h0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    afterEdge();
    checkOutput("window_after_flush", 32'(window), 32'hCAFEF0);
    checkOutput("fill_after_flush",   32'(fill),   32'd32);

    // reset, stray word in the masked cycle, then random consumption
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) fifo_q.push_back(32'(i));
    applyStimulus(1, 0, 0, 0, 1);
    afterEdge();
    checkOutput("error_masked", 32'(error), 32'h0);
    cycles = 0;
    while ((fifo_q.size() > 0 || m_bits.size() >= 24 || rd_prev) && cycles < 8000) begin
      adv = (m_bits.size() >= 24) ? int'($urandom_range(0, 24)) : 0;
      al  = ($urandom_range(0, 7) == 0);
      applyStimulus(1, adv, al, 0, 0);
      cycles++;
    end
    checkOutput("stream_drained", 32'(fifo_q.size()), 32'd0);

    afterEdge();
    afterEdge();
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
